// File: rtl/mult_check_sequencer.sv
// Multiplier checker: drives registered operands, waits a settle time,
// samples the product and flags any mismatch against a golden product.
module mult_check_sequencer #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_mismatch,
  output logic [15:0]        test_count,
  output logic [15:0]        err_count,
  input  logic               clear
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    OUT
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t             state;
  logic [7:0]         cnt;
  logic [2*WIDTH-1:0] golden;
  logic               done;

  // Full-width unsigned product of the operands currently driven
  assign golden = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};

  assign in_ready = (state == IDLE) & ~rst;
  assign done     = out_valid & out_ready;

  // Transaction sequencing: accept, settle, sample, present
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      out_p        <= '0;
      out_mismatch <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mul_a <= in_a;
            mul_b <= in_b;
            cnt   <= CNT_LOAD;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == 8'd0) begin
            out_p        <= mul_p;
            out_mismatch <= (mul_p != golden);
            out_valid    <= 1'b1;
            state        <= OUT;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating result counters; clear wins over a coincident increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      test_count <= '0;
      err_count  <= '0;
    end else if (clear) begin
      test_count <= '0;
      err_count  <= '0;
    end else if (done) begin
      if (test_count != 16'hFFFF)
        test_count <= test_count + 16'd1;
      if (out_mismatch && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mult_check_sequencer.sv
// Bench for mult_check_sequencer: two instances (settle 1 and 4) checked
// every cycle against a transaction-level model plus literal expectations.
module tb_mult_check_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2];
  logic       in_valid[2];
  logic       in_ready[2];
  logic [1:0] in_a[2];
  logic [1:0] in_b[2];
  logic [1:0] mul_a[2];
  logic [1:0] mul_b[2];
  logic [3:0] mul_p[2];
  logic       out_valid[2];
  logic       out_ready[2];
  logic [3:0] out_p[2];
  logic       out_mismatch[2];
  logic [15:0] tc[2];
  logic [15:0] ec[2];
  logic       clear[2];

  int vectors = 0;
  int miscompares = 0;
  int S[2] = '{1, 4};

  // Multiplier models: instance 0 optionally has P[0] stuck at 0,
  // instance 1 is correct but its product lags the operands by 3 cycles
  logic       stuck = 1'b0;
  logic [3:0] prod0;
  logic [3:0] d1, d2, d3;
  assign prod0    = {2'b00, mul_a[0]} * {2'b00, mul_b[0]};
  assign mul_p[0] = stuck ? (prod0 & 4'b1110) : prod0;
  always @(posedge clk) begin
    d1 <= {2'b00, mul_a[1]} * {2'b00, mul_b[1]};
    d2 <= d1;
    d3 <= d2;
  end
  assign mul_p[1] = d3;

  mult_check_sequencer #(.WIDTH(2), .SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]),
    .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_p(mul_p[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_p(out_p[0]), .out_mismatch(out_mismatch[0]),
    .test_count(tc[0]), .err_count(ec[0]), .clear(clear[0])
  );

  mult_check_sequencer #(.WIDTH(2), .SETTLE_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]),
    .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_p(mul_p[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_p(out_p[1]), .out_mismatch(out_mismatch[1]),
    .test_count(tc[1]), .err_count(ec[1]), .clear(clear[1])
  );

  task automatic chk(input string name, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d] t=%0t: got %0h expected %0h",
               name, k, $time, act, exp);
    end
  endtask

  // Transaction-level model: one pending pair, result due S edges
  // after the accept, held until taken, counters saturate
  int          cyc[2] = '{0, 0};
  int          due[2];
  bit          busy[2];
  bit          hres[2];
  logic [1:0]  ea[2];
  logic [1:0]  eb[2];
  logic [3:0]  ep[2];
  bit          emm[2];
  int          etc[2];
  int          eec[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [3:0] full;
      cyc[k]++;
      if (rst[k]) begin
        busy[k] = 0; hres[k] = 0;
        ea[k] = 0; eb[k] = 0; ep[k] = 0; emm[k] = 0;
        etc[k] = 0; eec[k] = 0;
      end else begin
        if (hres[k]) begin
          if (out_ready[k]) begin
            if (etc[k] < 65535) etc[k]++;
            if (emm[k] && eec[k] < 65535) eec[k]++;
            hres[k] = 0;
            busy[k] = 0;
          end
        end else if (busy[k]) begin
          if (cyc[k] == due[k]) begin
            full = {2'b00, ea[k]} * {2'b00, eb[k]};
            ep[k] = (k == 0 && stuck) ? (full & 4'b1110) : full;
            emm[k] = (ep[k] != full);
            hres[k] = 1;
          end
        end else if (in_valid[k]) begin
          ea[k] = in_a[k];
          eb[k] = in_b[k];
          busy[k] = 1;
          due[k] = cyc[k] + S[k];
        end
        if (clear[k]) begin
          etc[k] = 0;
          eec[k] = 0;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("m_in_ready", k, in_ready[k], !rst[k] && !busy[k] && !hres[k]);
      chk("m_out_valid", k, out_valid[k], hres[k]);
      chk("m_out_p", k, out_p[k], ep[k]);
      chk("m_mismatch", k, out_mismatch[k], emm[k]);
      chk("m_mul_a", k, mul_a[k], ea[k]);
      chk("m_mul_b", k, mul_b[k], eb[k]);
      chk("m_test_count", k, tc[k], etc[k]);
      chk("m_err_count", k, ec[k], eec[k]);
    end
  end

  // Offer a pair, wait for the result, optionally stall, then take it
  task automatic run(input int k, input logic [1:0] a, input logic [1:0] b,
                     input int hold, input logic [3:0] xp, input logic xmm);
    int n;
    @(negedge clk);
    chk("pre_ready", k, in_ready[k], 1);
    in_valid[k] = 1; in_a[k] = a; in_b[k] = b;
    @(negedge clk);
    in_valid[k] = 0;
    n = 0;
    while (!out_valid[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", k, n, S[k]);
    chk("out_p", k, out_p[k], xp);
    chk("mismatch", k, out_mismatch[k], xmm);
    repeat (hold) begin
      in_valid[k] = 1; in_a[k] = ~a; in_b[k] = ~b;
      @(negedge clk);
      chk("hold_p", k, out_p[k], xp);
      chk("hold_valid", k, out_valid[k], 1);
      chk("hold_ready", k, in_ready[k], 0);
      chk("hold_mul_a", k, mul_a[k], a);
    end
    out_ready[k] = 1;
    @(negedge clk);
    out_ready[k] = 0;
    in_valid[k] = 0;
    chk("post_valid", k, out_valid[k], 0);
    chk("post_ready", k, in_ready[k], 1);
  endtask

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1; in_valid[k] = 0; in_a[k] = 0; in_b[k] = 0;
      out_ready[k] = 0; clear[k] = 0;
    end
    repeat (2) @(negedge clk);
    chk("rst_ready", 0, in_ready[0], 0);
    chk("rst_out_p", 0, out_p[0], 0);
    chk("rst_tc", 0, tc[0], 0);
    rst[0] = 0; rst[1] = 0;

    // Correct multiplier, 3*3
    run(0, 2'd3, 2'd3, 0, 4'd9, 1'b0);
    chk("tc_a", 0, tc[0], 1);
    chk("ec_a", 0, ec[0], 0);

    // Clear, then P[0] stuck at 0
    @(negedge clk); clear[0] = 1;
    @(negedge clk); clear[0] = 0;
    chk("clr_tc", 0, tc[0], 0);
    stuck = 1;
    run(0, 2'd1, 2'd3, 0, 4'd2, 1'b1);
    run(0, 2'd3, 2'd2, 0, 4'd6, 1'b0);
    stuck = 0;
    chk("tc_b", 0, tc[0], 2);
    chk("ec_b", 0, ec[0], 1);

    // Consumer stalls 5 cycles
    run(0, 2'd2, 2'd3, 5, 4'd6, 1'b0);
    chk("tc_c", 0, tc[0], 3);
    chk("ec_c", 0, ec[0], 1);

    // Reset during settle aborts the pair
    @(negedge clk);
    in_valid[0] = 1; in_a[0] = 2'd3; in_b[0] = 2'd1;
    @(negedge clk);
    in_valid[0] = 0;
    rst[0] = 1;
    #1;
    chk("ab_valid", 0, out_valid[0], 0);
    chk("ab_ready", 0, in_ready[0], 0);
    chk("ab_mul_a", 0, mul_a[0], 0);
    chk("ab_out_p", 0, out_p[0], 0);
    chk("ab_tc", 0, tc[0], 0);
    @(negedge clk);
    rst[0] = 0;
    #1;
    chk("ab_ready_after", 0, in_ready[0], 1);
    run(0, 2'd2, 2'd2, 0, 4'd4, 1'b0);
    chk("tc_d", 0, tc[0], 1);

    // Clear coincident with a mismatching handshake
    stuck = 1;
    @(negedge clk);
    in_valid[0] = 1; in_a[0] = 2'd1; in_b[0] = 2'd1;
    @(negedge clk);
    in_valid[0] = 0;
    n = 0;
    while (!out_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("clr_mm", 0, out_mismatch[0], 1);
    out_ready[0] = 1; clear[0] = 1;
    @(negedge clk);
    out_ready[0] = 0; clear[0] = 0;
    stuck = 0;
    chk("clr_tc2", 0, tc[0], 0);
    chk("clr_ec2", 0, ec[0], 0);

    // Settle of 4 against a 3-cycle-late multiplier, 20 pairs
    for (int i = 0; i < 20; i++) begin
      logic [1:0] a, b;
      logic [3:0] p;
      a = 2'(i);
      b = 2'(i >> 2);
      p = {2'b00, a} * {2'b00, b};
      run(1, a, b, i % 2, p, 1'b0);
    end
    chk("s4_tc", 1, tc[1], 20);
    chk("s4_ec", 1, ec[1], 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
